// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one fifo write port among NUM_REQ bursting requesters.
// Optional ARB_SPACE_RESERVE_EN: grant only when the fifo has room for a full MAX_BURST burst.
module fifo_wr_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int FIFO_WIDTH     = 8,
  parameter int LOG_FIFO_DEPTH = 4,
  parameter int MAX_BURST      = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_last,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_fifo_wr,
  output logic [FIFO_WIDTH-1:0]         o_fifo_data,
  input  logic                          i_fifo_full,
  input  logic [LOG_FIFO_DEPTH:0]       i_fifo_entries,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy,
  output logic                          o_burst_cut
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int FW = LOG_FIFO_DEPTH + 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [FW-1:0] DEPTH    = FW'(1 << LOG_FIFO_DEPTH);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]       gidx_q, gidx_d;
  logic [CW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                cut_q, cut_d;

  logic                space_ok;
  logic                found;
  logic [PW-1:0]       sel;
  logic [PW-1:0]       scan;
  logic                g_valid;
  logic                g_last;
  logic                beat;

`ifdef ARB_SPACE_RESERVE_EN
  localparam logic [FW-1:0] RESERVE = FW'(MAX_BURST);
  logic [FW-1:0] free;
  assign free     = DEPTH - i_fifo_entries;
  assign space_ok = (free >= RESERVE);
`else
  // A well-formed fifo never reports more than DEPTH entries, so this always passes.
  assign space_ok = (i_fifo_entries <= DEPTH);
`endif

  always_comb begin
    found = 1'b0;
    sel   = rr_ptr_q;
    scan  = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && i_req_valid[scan]) begin
        found = 1'b1;
        sel   = scan;
      end
      scan = (scan == LAST_IDX) ? '0 : scan + 1'b1;
    end
  end

  always_comb begin
    g_valid     = 1'b0;
    g_last      = 1'b0;
    o_fifo_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gidx_q == PW'(k)) begin
        g_valid     = i_req_valid[k];
        g_last      = i_req_last[k];
        o_fifo_data = i_req_data[k*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  // Reset gates the handshake immediately so no beat is accepted in the reset cycle.
  always_comb begin
    o_req_ready = '0;
    o_fifo_wr   = 1'b0;
    if (state_q == BURST && !i_reset && !i_fifo_full) begin
      o_req_ready = grant_q;
      o_fifo_wr   = g_valid;
    end
  end

  assign beat = o_fifo_wr;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gidx_d     = gidx_q;
    beat_cnt_d = beat_cnt_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    cut_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && space_ok) begin
          state_d    = BURST;
          gidx_d     = sel;
          beat_cnt_d = '0;
          busy_d     = 1'b1;
          grant_d    = '0;
          for (int k = 0; k < NUM_REQ; k++) begin
            if (sel == PW'(k)) grant_d[k] = 1'b1;
          end
        end
      end
      BURST: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (g_last || beat_cnt_q == CNT_LAST) begin
            state_d  = IDLE;
            grant_d  = '0;
            busy_d   = 1'b0;
            rr_ptr_d = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
            cut_d    = !g_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      beat_cnt_q <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      cut_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gidx_q     <= gidx_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      cut_q      <= cut_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_busy      = busy_q;
  assign o_burst_cut = cut_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester beat queues drive the DUT and a
// scoreboard of expected fifo writes is checked on every o_fifo_wr.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ        = 2;
  localparam int FIFO_WIDTH     = 8;
  localparam int LOG_FIFO_DEPTH = 4;
  localparam int MAX_BURST      = 4;

  logic                          clk = 1'b0;
  logic                          reset;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr;
  logic [FIFO_WIDTH-1:0]         fifo_data;
  logic                          fifo_full;
  logic [LOG_FIFO_DEPTH:0]       fifo_entries;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          burst_cut;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] sb_q[$];
  int         n_tests;
  int         n_fail;
  logic       last_wr;
  logic [11:0] pat;
  logic       stall_wr;

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .FIFO_WIDTH(FIFO_WIDTH),
    .LOG_FIFO_DEPTH(LOG_FIFO_DEPTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(req_valid), .i_req_last(req_last), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_fifo_wr(fifo_wr), .o_fifo_data(fifo_data),
    .i_fifo_full(fifo_full), .i_fifo_entries(fifo_entries),
    .o_grant(grant), .o_busy(busy), .o_burst_cut(burst_cut)
  );

  always #5 clk = ~clk;

  assign fifo_full = (fifo_entries == 5'd16);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    if (q0.size() > 0) begin
      req_valid[0]   = 1'b1;
      req_last[0]    = q0[0][8];
      req_data[7:0]  = q0[0][7:0];
    end
    if (q1.size() > 0) begin
      req_valid[1]   = 1'b1;
      req_last[1]    = q1[0][8];
      req_data[15:8] = q1[0][7:0];
    end
  endtask

  task automatic applyStimulus(input int k, input logic [7:0] d, input logic l);
    if (k == 0) q0.push_back({l, d});
    else        q1.push_back({l, d});
    refresh();
  endtask

  // Sample mid-cycle, then retire accepted beats just after the rising edge.
  task automatic cycle();
    logic [NUM_REQ-1:0] acc;
    @(negedge clk);
    acc     = req_valid & req_ready;
    last_wr = fifo_wr;
    if (fifo_wr) begin
      if (sb_q.size() == 0) checkOutput("write_expected", 32'(sb_q.size()), 32'd1);
      else checkOutput("fifo_data", 32'(fifo_data), 32'(sb_q.pop_front()));
    end
    @(posedge clk);
    #1;
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
    refresh();
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    sb_q.delete();
    refresh();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    last_wr      = 1'b0;
    fifo_entries = '0;
    reset        = 1'b1;
    refresh();
    @(posedge clk);
    #1;
    cycle();
    cycle();
    reset = 1'b0;
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cut", 32'(burst_cut), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_wr", 32'(fifo_wr), 32'd0);

    // single 3-beat burst from req0
    applyStimulus(0, 8'hA1, 1'b0); sb_q.push_back(8'hA1);
    applyStimulus(0, 8'hA2, 1'b0); sb_q.push_back(8'hA2);
    applyStimulus(0, 8'hA3, 1'b1); sb_q.push_back(8'hA3);
    cycle();
    checkOutput("t1_grant", 32'(grant), 32'd1);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    pat = '0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      pat = {pat[10:0], last_wr};
    end
    checkOutput("t1_b2b", 32'(pat[2:0]), 32'd7);
    checkOutput("t1_grant_end", 32'(grant), 32'd0);
    checkOutput("t1_busy_end", 32'(busy), 32'd0);
    checkOutput("t1_cut", 32'(burst_cut), 32'd0);
    checkOutput("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // two requesters alternating 2-beat bursts
    do_reset();
    applyStimulus(0, 8'h01, 1'b0); applyStimulus(0, 8'h02, 1'b1);
    applyStimulus(0, 8'h03, 1'b0); applyStimulus(0, 8'h04, 1'b1);
    applyStimulus(1, 8'h11, 1'b0); applyStimulus(1, 8'h12, 1'b1);
    applyStimulus(1, 8'h13, 1'b0); applyStimulus(1, 8'h14, 1'b1);
    sb_q = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h03, 8'h04, 8'h13, 8'h14};
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      pat = {pat[10:0], last_wr};
    end
    checkOutput("t2_wr_pattern", 32'(pat), 32'b011011011011);
    checkOutput("t2_sb_empty", 32'(sb_q.size()), 32'd0);

    // req1 overruns MAX_BURST and is cut
    do_reset();
    for (int i = 0; i < 6; i++) applyStimulus(1, 8'(8'h30 + i), 1'b0);
    sb_q = '{8'h30, 8'h31, 8'h32, 8'h33};
    cycle();
    checkOutput("t3_grant1", 32'(grant), 32'd2);
    applyStimulus(0, 8'h40, 1'b0);
    applyStimulus(0, 8'h41, 1'b1);
    sb_q.push_back(8'h40); sb_q.push_back(8'h41);
    sb_q.push_back(8'h34); sb_q.push_back(8'h35);
    for (int i = 0; i < 4; i++) cycle();
    checkOutput("t3_cut_pulse", 32'(burst_cut), 32'd1);
    checkOutput("t3_grant_rel", 32'(grant), 32'd0);
    cycle();
    checkOutput("t3_cut_clear", 32'(burst_cut), 32'd0);
    checkOutput("t3_grant0", 32'(grant), 32'd1);
    cycle(); cycle(); cycle();
    checkOutput("t3_grant1_again", 32'(grant), 32'd2);
    cycle(); cycle();
    checkOutput("t3_sb_empty", 32'(sb_q.size()), 32'd0);
    checkOutput("t3_hold_busy", 32'(busy), 32'd1);

    // fifo full mid-burst stalls without loss; last on the MAX_BURST-th beat
    do_reset();
    fifo_entries = '0;
    applyStimulus(0, 8'h50, 1'b0); applyStimulus(0, 8'h51, 1'b0);
    applyStimulus(0, 8'h52, 1'b0); applyStimulus(0, 8'h53, 1'b1);
    sb_q = '{8'h50, 8'h51, 8'h52, 8'h53};
    cycle();
    cycle();
    fifo_entries = 5'd16;
    #1;
    checkOutput("t4_full_ready", 32'(req_ready), 32'd0);
    checkOutput("t4_full_wr", 32'(fifo_wr), 32'd0);
    stall_wr = 1'b0;
    cycle(); stall_wr |= last_wr;
    cycle(); stall_wr |= last_wr;
    checkOutput("t4_stall_nowr", 32'(stall_wr), 32'd0);
    fifo_entries = 5'd15;
    cycle(); cycle(); cycle();
    checkOutput("t4_grant_end", 32'(grant), 32'd0);
    checkOutput("t4_no_cut", 32'(burst_cut), 32'd0);
    checkOutput("t4_sb_empty", 32'(sb_q.size()), 32'd0);
    fifo_entries = '0;

    // reset mid-burst abandons the burst and restarts round-robin at req0
    do_reset();
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'(8'h60 + i), 1'(i == 3));
    sb_q = '{8'h60, 8'h61};
    cycle(); cycle(); cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checkOutput("t5_rst_grant", 32'(grant), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    applyStimulus(1, 8'h70, 1'b1);
    sb_q.push_back(8'h62); sb_q.push_back(8'h63); sb_q.push_back(8'h70);
    cycle();
    checkOutput("t5_req0_first", 32'(grant), 32'd1);
    cycle(); cycle(); cycle();
    checkOutput("t5_req1_next", 32'(grant), 32'd2);
    cycle();
    checkOutput("t5_grant_end", 32'(grant), 32'd0);
    checkOutput("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    // space reservation before granting
    do_reset();
    fifo_entries = 5'd14;
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'(8'h80 + i), 1'(i == 3));
    sb_q = '{8'h80, 8'h81, 8'h82, 8'h83};
`ifdef ARB_SPACE_RESERVE_EN
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkOutput("t6_reserve_hold", 32'(grant), 32'd0);
    end
    fifo_entries = 5'd12;
    cycle();
    checkOutput("t6_grant", 32'(grant), 32'd1);
`else
    cycle();
    checkOutput("t6_grant", 32'(grant), 32'd1);
`endif
    for (int i = 0; i < 4; i++) cycle();
    checkOutput("t6_grant_end", 32'(grant), 32'd0);
    checkOutput("t6_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
